// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: reset vector, address
// width, sequential step and the 1-bit state encoding.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 32;

    // Boot ROM entry point loaded into the fetch PC on reset.
    localparam logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000;

    // Sequential fetch advances one 32-bit instruction.
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // SEQ: normal fetch. HOLD: a taken redirect is waiting for the delay
    // slot at pc_f to be accepted.
    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer.
// Holds the fetch address, steps it by 4 on each accepted fetch, and applies
// branch/jump and exception redirects. A taken branch that arrives while the
// delay slot cannot be accepted is parked in a hold register until it is.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_f           fetch hold from hazard unit
//   inst_addr_ok      instruction memory accepted pc_f this cycle
//   taken_d/target_d  decode-stage taken redirect and its target
//   exc_valid/exc_pc  exception/eret redirect and its target
//   pc_f              current fetch address (registered)
//   inst_req          fetch request valid
//   pc_adel           pc_f misaligned
//   redirect_pending  a held redirect is waiting (state HOLD)
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_f,
    input  logic              inst_addr_ok,
    input  logic              taken_d,
    input  logic [ADDR_W-1:0] target_d,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    output logic [ADDR_W-1:0] pc_f,
    output logic              inst_req,
    output logic              pc_adel,
    output logic              redirect_pending
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              run_q, run_d;
    logic              advance_c;

    // run_q keeps inst_req low for the cycle in which reset is released.
    assign pc_f             = pc_q;
    assign pc_adel          = |pc_q[1:0];
    assign inst_req         = run_q & ~pc_adel;
    assign redirect_pending = (state_q == ST_HOLD);
    assign advance_c        = inst_req & inst_addr_ok & ~stall_f;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEQ;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            run_q   <= run_d;
        end
    end

    // Next-PC selection: exception > held target > taken target > +4 > hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        run_d   = 1'b1;

        if (exc_valid) begin
            // Exception wins regardless of stall and drops any held target.
            pc_d    = exc_pc;
            tgt_d   = '0;
            state_d = ST_SEQ;
        end else begin
            unique case (state_q)
                ST_SEQ: begin
                    if (taken_d) begin
                        if (advance_c) begin
                            // The accepted fetch at pc_f is the delay slot.
                            pc_d = target_d;
                        end else begin
                            tgt_d   = target_d;
                            state_d = ST_HOLD;
                        end
                    end else if (advance_c) begin
                        pc_d = ADDR_W'(pc_q + PC_STEP);
                    end
                end
                ST_HOLD: begin
                    // taken_d cannot legally arrive here and is ignored.
                    if (advance_c) begin
                        pc_d    = tgt_q;
                        state_d = ST_SEQ;
                    end
                end
                default: state_d = ST_SEQ;
            endcase
        end
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a hand-written
// held-redirect latency sequence, then randomized stimulus against a
// queue-based reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        inst_addr_ok;
    logic        taken_d;
    logic [31:0] target_d;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] pc_f;
    logic        inst_req;
    logic        pc_adel;
    logic        redirect_pending;

    int tests_run = 0;
    int tests_failed = 0;

    pc_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .stall_f          (stall_f),
        .inst_addr_ok     (inst_addr_ok),
        .taken_d          (taken_d),
        .target_d         (target_d),
        .exc_valid        (exc_valid),
        .exc_pc           (exc_pc),
        .pc_f             (pc_f),
        .inst_req         (inst_req),
        .pc_adel          (pc_adel),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode must not issue a new taken branch while a redirect is held.
    always @(posedge clk) begin
        assert (rst || !(redirect_pending && taken_d))
            else $error("protocol violation: taken_d while redirect pending");
    end

    // Reference model: fetch address, pending redirect queue, live flag.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_live;

    function automatic bit m_req();
        return m_live && (m_pc[1:0] == 2'b00);
    endfunction

    task automatic model_step();
        bit adv;
        if (rst) begin
            m_pc   = 32'hBFC0_0000;
            m_pend.delete();
            m_live = 1'b0;
        end else begin
            adv = m_req() && inst_addr_ok && !stall_f;
            if (exc_valid) begin
                m_pc = exc_pc;
                m_pend.delete();
            end else if (m_pend.size() != 0) begin
                if (adv) m_pc = m_pend.pop_front();
            end else if (taken_d) begin
                if (adv) m_pc = target_d;
                else     m_pend.push_back(target_d);
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end
            m_live = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit ok, input bit tk,
                         input logic [31:0] tg, input bit ex, input logic [31:0] ep);
        rst = r; stall_f = s; inst_addr_ok = ok; taken_d = tk;
        target_d = tg; exc_valid = ex; exc_pc = ep;
    endtask

    typedef struct {
        bit          rst;
        bit          stall;
        bit          ok;
        bit          taken;
        logic [31:0] target;
        bit          exc;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        bit          exp_req;
        bit          exp_adel;
        bit          exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit s, bit ok, bit tk, logic [31:0] tg, bit ex,
                                logic [31:0] ep, logic [31:0] pc, bit rq, bit ad, bit pd);
        vec_t v;
        v.rst = r; v.stall = s; v.ok = ok; v.taken = tk; v.target = tg;
        v.exc = ex; v.epc = ep; v.exp_pc = pc; v.exp_req = rq; v.exp_adel = ad;
        v.exp_pend = pd;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_tgt;
        int          hold_cycles;
        int          waited;
        bit          seen;

        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        m_pc = 32'hBFC0_0000;
        m_live = 1'b0;

        //          rst st ok tk target        ex epc           exp_pc        rq ad pd
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'hBFC0_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h1234_0000, 1, 32'h5678_0000, 32'hBFC0_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0004, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0008, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_000C, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0010, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hBFC0_0100, 0, 32'h0,         32'hBFC0_0100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0010, 32'hBFC0_0010, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hBFC0_0100, 0, 32'h0,         32'hBFC0_0010, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0010, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0010, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0100, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hBFC0_0200, 0, 32'h0,         32'hBFC0_0100, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0380, 32'hBFC0_0380, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0384, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hBFC0_0102, 0, 32'h0,         32'hBFC0_0102, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0102, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0040, 0, 32'h0,         32'h0000_0000, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         32'hBFC0_0004, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].ok, vecs[i].taken,
                  vecs[i].target, vecs[i].exc, vecs[i].epc);
            tick();
            chk($sformatf("vec%0d pc_f", i), pc_f, vecs[i].exp_pc);
            chk($sformatf("vec%0d inst_req", i), 32'(inst_req), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d pc_adel", i), 32'(pc_adel), 32'(vecs[i].exp_adel));
            chk($sformatf("vec%0d redirect_pending", i), 32'(redirect_pending), 32'(vecs[i].exp_pend));
        end

        // Held redirect released after a variable stall; new PC must appear
        // exactly one cycle after the first advance.
        for (int k = 0; k < 4; k++) begin
            exp_tgt     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            hold_cycles = 1 + k * 2;
            drive(0, 1, 1, 1, exp_tgt, 0, 32'h0);
            tick();
            drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
            for (int c = 0; c < hold_cycles; c++) tick();
            chk($sformatf("hold%0d pending", k), 32'(redirect_pending), 32'd1);
            drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
            seen   = 1'b0;
            waited = 0;
            while (!seen && waited < 20) begin
                tick();
                waited++;
                if (pc_f === exp_tgt && redirect_pending === 1'b0) seen = 1'b1;
            end
            chk($sformatf("hold%0d latency", k), 32'(waited), 32'd1);
            chk($sformatf("hold%0d pc_f", k), pc_f, exp_tgt);
        end

        // Randomized phase against the reference model.
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            stall_f      = ($urandom_range(0, 3) == 0);
            inst_addr_ok = ($urandom_range(0, 3) != 0);
            taken_d      = (m_pend.size() == 0) && ($urandom_range(0, 5) == 0);
            target_d     = $urandom();
            if ($urandom_range(0, 15) != 0) target_d[1:0] = 2'b00;
            exc_valid    = ($urandom_range(0, 31) == 0);
            exc_pc       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom();
            if ($urandom_range(0, 15) != 0) exc_pc[1:0] = 2'b00;
            tick();
            chk("rand pc_f", pc_f, m_pc);
            chk("rand inst_req", 32'(inst_req), 32'(m_req()));
            chk("rand pc_adel", 32'(pc_adel), 32'(m_pc[1:0] != 2'b00));
            chk("rand redirect_pending", 32'(redirect_pending), 32'(m_pend.size() != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_sequencer
